// File: rtl/config_chain_driver_if.sv
// Bundles the host handshake and the serial configuration-chain pins of config_chain_driver.
// The driver uses modport master; the host/chain side (or a testbench) uses modport slave.
interface config_chain_driver_if #(
  parameter int CHAIN_LEN = 4
);
  // Host side
  logic                 start;
  logic [CHAIN_LEN-1:0] cfg_data;
  logic                 hold;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] readback_data;

  // Chain side
  logic                 configuration_output;
  logic                 configuration_enable;
  logic                 configuration_input;

  modport master (
    input  start,
    input  cfg_data,
    input  hold,
    input  configuration_input,
    output configuration_output,
    output configuration_enable,
    output busy,
    output done,
    output readback_data
  );

  modport slave (
    output start,
    output cfg_data,
    output hold,
    output configuration_input,
    input  configuration_output,
    input  configuration_enable,
    input  busy,
    input  done,
    input  readback_data
  );
endinterface

// File: rtl/config_chain_driver.sv
// Serially loads a CHAIN_LEN-bit image into a configuration chain, MSB first, with stall support.
// Define CONFIG_CHAIN_READBACK_EN to capture the chain's previous contents into readback_data.
module config_chain_driver #(
  parameter int CHAIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  config_chain_driver_if.master bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  if (CHAIN_LEN < 1 || CHAIN_LEN > 1024) begin : g_bad_len
    $error("config_chain_driver: CHAIN_LEN must be in 1..1024");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CHAIN_LEN-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept;
  logic                 shift_en;
  logic                 last_shift;
  logic                 busy;
  logic                 done;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_shift = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = !bus.hold;
        if (shift_en && last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift datapath: image is sent MSB first, one bit per enabled cycle
  // ---------------------------------------------------------------------------
  // NOTE: datapath registers also take the reset so a reset leaves no stale image behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= bus.cfg_data;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.configuration_output = shift_q[CHAIN_LEN-1];
  assign bus.configuration_enable = shift_en;
  assign bus.busy                 = busy;
  assign bus.done                 = done;

  // ---------------------------------------------------------------------------
  // Readback: the chain emits its old contents from the output end first, so
  // the k-th bit returned belongs at position CHAIN_LEN-1-k of the image.
  // ---------------------------------------------------------------------------
`ifdef CONFIG_CHAIN_READBACK_EN
  logic [CHAIN_LEN-1:0] readback_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      readback_q <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (int'(cnt_q) == CHAIN_LEN - 1 - i) begin
          readback_q[i] <= bus.configuration_input;
        end
      end
    end
  end

  assign bus.readback_data = readback_q;
`else
  logic unused_configuration_input;

  assign unused_configuration_input = bus.configuration_input;
  assign bus.readback_data          = '0;
`endif

endmodule

// File: tb/tb_config_chain_driver.sv
// Scoreboard bench for config_chain_driver (CHAIN_LEN=4) against a 4-bit shift-register chain model.
// Readback expectations follow CONFIG_CHAIN_READBACK_EN; the chain load checks apply in both builds.
module tb_config_chain_driver;

  localparam int LEN = 4;

  typedef struct {
    logic [LEN-1:0] rb;
    logic [LEN-1:0] chain;
  } done_exp_t;

  logic clk;
  logic reset;
  logic [LEN-1:0] chain;

  logic      exp_bits[$];
  done_exp_t exp_done[$];

  int n_cmp;
  int n_err;

  config_chain_driver_if #(.CHAIN_LEN(LEN)) bus ();

  config_chain_driver #(.CHAIN_LEN(LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External configuration chain: bit 0 nearest its input, bit 3 at its output.
  initial chain = '0;
  always @(posedge clk) begin
    if (bus.configuration_enable) chain <= {chain[LEN-2:0], bus.configuration_output};
  end
  assign bus.configuration_input = chain[LEN-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0] rb_exp(input logic [LEN-1:0] v);
`ifdef CONFIG_CHAIN_READBACK_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Monitor: pops an expected serial bit for each strobe and a result at each done.
  always @(negedge clk) begin
    if (bus.configuration_enable) begin
      if (exp_bits.size() == 0) begin
        check("unexpected_shift", 32'd1, 32'd0);
      end else begin
        check("serial_bit", 32'(bus.configuration_output), 32'(exp_bits.pop_front()));
      end
    end
    if (bus.done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        done_exp_t e;
        e = exp_done.pop_front();
        check("readback_data", 32'(bus.readback_data), 32'(e.rb));
        check("chain_contents", 32'(chain), 32'(e.chain));
      end
    end
  end

  // One load: exp_mask marks the cycles (after the accept edge) with the strobe high,
  // exp_done_idx is the cycle in which done is expected.
  task automatic do_load(input logic [LEN-1:0] cfg, input logic [LEN-1:0] old_chain,
                         input int hold_from, input int hold_len, input int pulse_at,
                         input logic [31:0] exp_mask, input int exp_done_idx);
    logic [31:0] mask;
    int          done_idx;
    for (int i = LEN - 1; i >= 0; i--) exp_bits.push_back(cfg[i]);
    exp_done.push_back('{rb: rb_exp(old_chain), chain: cfg});
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.cfg_data = cfg;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.cfg_data = ~cfg;
    mask     = '0;
    done_idx = -1;
    for (int idx = 0; idx < 40 && done_idx < 0; idx++) begin
      bus.hold  = (idx >= hold_from) && (idx < hold_from + hold_len);
      bus.start = (idx == pulse_at);
      if (idx == pulse_at) bus.cfg_data = '0;
      @(negedge clk);
      if (bus.done) begin
        done_idx = idx;
      end else begin
        check("busy_in_shift", 32'(bus.busy), 32'd1);
        if (bus.configuration_enable) mask[idx] = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    check("enable_pattern", mask, exp_mask);
    check("done_latency", 32'(done_idx), 32'(exp_done_idx));
    @(negedge clk);
    check("done_single_cycle", 32'(bus.done), 32'd0);
    check("idle_not_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int seen_done;
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_enable", 32'(bus.configuration_enable), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_readback", 32'(bus.readback_data), 32'd0);
    check("reset_serial_out", 32'(bus.configuration_output), 32'd0);

    // Basic load, then reload capturing the first image.
    do_load(4'b1011, 4'b0000, -1, 0, -1, 32'h0000_000F, 4);
    do_load(4'b0110, 4'b1011, -1, 0, -1, 32'h0000_000F, 4);
    // Stall for 3 cycles after the 2nd shift: strobe cycles 0,1,5,6; done 3 cycles late.
    do_load(4'b1100, 4'b0110, 2, 3, -1, 32'h0000_0063, 7);
    // Start re-pulsed mid-shift with cfg_data=0 must be ignored.
    do_load(4'b1111, 4'b1100, -1, 0, 1, 32'h0000_000F, 4);

    // Abort 4'b1010 with reset after two shifts.
    for (int i = LEN - 1; i >= 0; i--) exp_bits.push_back(1'(4'b1010 >> i));
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.cfg_data = 4'b1010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobe_before_edge", 32'(bus.configuration_enable), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_enable", 32'(bus.configuration_enable), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_readback", 32'(bus.readback_data), 32'd0);
    exp_bits.delete();
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1;
    end
    check("no_activity_after_abort", 32'(seen_done), 32'd0);

    // Chain was 1111; the strobe was still high on the reset edge, so 1,0,1 went in: 1101.
    do_load(4'b0101, 4'b1101, -1, 0, -1, 32'h0000_000F, 4);

    repeat (2) @(posedge clk);
    check("bits_queue_drained", 32'(exp_bits.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
